mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbitrates a single-ported unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (DM).
- Sits between the pipeline stages and the memory inside toplevel.
- Sequences each access through a small FSM and returns read data with a one-cycle ack.
- Drives per-requester stall signals so the hazard logic freezes PC and pipeline registers while an access is pending.
- DM has priority, except when a starvation limit forces an IF grant.

Parameters:
AW, 32, address width
DW, 32, data width
STARVE_LIM, 4, consecutive DM grants with IF waiting before IF is forced to win (1..15)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset (0 = reset)
IF_Req  in  1  fetch read request, level, held until IF_Ack
IF_Addr  in  AW  fetch address
IF_Ack  out  1  one-cycle pulse; IF_RData valid this cycle
IF_RData  out  DW  fetched instruction
DM_Req  in  1  data request, level, held until DM_Ack
DM_We  in  1  1 = write, 0 = read
DM_Addr  in  AW  data address
DM_WData  in  DW  store data
DM_Ack  out  1  one-cycle pulse; DM_RData valid this cycle (reads)
DM_RData  out  DW  load data
Stall_IF  out  1  IF_Req & ~IF_Ack
Stall_DM  out  1  DM_Req & ~DM_Ack
Mem_Req  out  1  access strobe to memory, held until Mem_Ready
Mem_We  out  1  write enable to memory
Mem_Addr  out  AW  memory address
Mem_WData  out  DW  memory write data
Mem_RData  in  DW  memory read data, valid when Mem_Ready=1
Mem_Ready  in  1  memory completion, sampled only while Mem_Req=1

Behaviour:
- Reset (Reset=0, asynchronous): state=IDLE. Mem_Req, Mem_We, IF_Ack and DM_Ack are 0. Mem_Addr, Mem_WData, IF_RData and DM_RData are 0. Starvation counter is 0.
- Reset mid-access: Mem_Req drops immediately and the in-flight access is abandoned with no ack.
- All outputs except Stall_IF and Stall_DM are registered. The stall signals are combinational from Req and the registered Ack.
- FSM states: IDLE, ISSUE, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, winner selected: latch owner, address, data and We, then go to ISSUE.
  - Only one request active: that requester wins.
  - Both active: DM wins if starve_cnt < STARVE_LIM, otherwise IF wins.
- ISSUE: Mem_Req=1 with latched fields held stable.
  - Mem_Ready=1: capture Mem_RData into the owner's RData register and go to DONE.
  - Otherwise stay in ISSUE, with no timeout.
- DONE: owner's Ack=1 for exactly one cycle and Mem_Req=0; next state is IDLE. Requests are ignored in DONE, so a requester drops Req on the edge after seeing Ack.
- Latency: Req sampled in cycle 0, Mem_Req high from cycle 1, Mem_Ready in cycle k (k≥1), Ack in cycle k+1, IDLE again in cycle k+2.
- Minimum is 3 cycles per access, so back-to-back accesses never overlap.
- IF_RData and DM_RData hold their last value until that requester's next read completes.
- A DM write leaves DM_RData unchanged.
- Starvation counter:
  - Increments on a DM grant while IF_Req=1, saturating at STARVE_LIM.
  - Clears on any IF grant.
- Requester changes to Addr, WData or We after the grant have no effect until the next grant.

Optional Feature:
ARB_STATS_EN
- Defined: adds output Conflict_Cnt (32 bits, reset 0). It increments in each IDLE cycle where IF_Req and DM_Req are both 1, and wraps at 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - State encodings IDLE=2'd0, ISSUE=2'd1, DONE=2'd2.
  - Owner encodings OWN_IF=1'b0, OWN_DM=1'b1.
- One natural sub-module, mem_arb_starve_ctr: saturating counter with inc/clr inputs and an at_limit output.

Test Plan:
- Reset=0 asserted mid-ISSUE (Mem_Req=1) -> Mem_Req=0 immediately; no ack follows; IDLE after release.
- Lone IF read of 0x00000040, Mem_Ready after 1 cycle with 0x8C080004 -> IF_Ack in cycle 2, IF_RData=0x8C080004, Stall_IF high cycles 0..1.
- IF and DM both requesting, DM read 0x100 -> DM served first; Stall_IF stays 1 through DM_Ack; IF served next.
- DM_Req held continuously for 5 accesses with IF_Req=1, STARVE_LIM=4 -> grants in order DM,DM,DM,DM,IF, then DM resumes.
- DM write of 0xDEADBEEF to 0x200 with Mem_Ready delayed 3 cycles -> Mem_We=1 and Mem_WData stable for all 3 cycles; DM_Ack in cycle 5; DM_RData unchanged.
- With ARB_STATS_EN, 3 IDLE cycles with both Req high across the sequence -> Conflict_Cnt=3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states, owner codes
// and the priority rule used when fetch and data requests collide.
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Wide enough for the largest supported starvation limit (15).
  localparam int CNT_W = 4;

  // DM wins unless IF is also waiting and has been passed over too often.
  function automatic logic pick_dm(input logic if_req, input logic dm_req,
                                   input logic at_limit);
    return dm_req & ~(if_req & at_limit);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive DM grants taken while IF was waiting.
// at_limit tells the arbiter that the next collision must go to IF.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIM = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIM_C = CNT_W'(LIM);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIM_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_limit = (cnt >= LIM_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch (IF) and data (DM).
// Optional ARB_STATS_EN adds a Conflict_Cnt output counting IDLE-cycle collisions.
//
// state | meaning
// IDLE  | no access in flight; pick a winner and latch its request
// ISSUE | Mem_Req held with latched fields until Mem_Ready
// DONE  | one-cycle ack to the owner; requests ignored
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          IF_Req,
  input  logic [AW-1:0] IF_Addr,
  output logic          IF_Ack,
  output logic [DW-1:0] IF_RData,
  input  logic          DM_Req,
  input  logic          DM_We,
  input  logic [AW-1:0] DM_Addr,
  input  logic [DW-1:0] DM_WData,
  output logic          DM_Ack,
  output logic [DW-1:0] DM_RData,
  output logic          Stall_IF,
  output logic          Stall_DM,
  output logic          Mem_Req,
  output logic          Mem_We,
  output logic [AW-1:0] Mem_Addr,
  output logic [DW-1:0] Mem_WData,
  input  logic [DW-1:0] Mem_RData,
  input  logic          Mem_Ready
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]   Conflict_Cnt
`endif
);

  logic [1:0] state;
  logic       owner;
  logic       at_limit;
  logic       dm_win;
  logic       if_win;

  assign dm_win = (state == IDLE) && pick_dm(IF_Req, DM_Req, at_limit);
  assign if_win = (state == IDLE) && IF_Req && !dm_win;

  mem_arb_starve_ctr #(
    .LIM(STARVE_LIM)
  ) u_starve (
    .Clk     (Clk),
    .Reset   (Reset),
    .inc     (dm_win && IF_Req),
    .clr     (if_win),
    .at_limit(at_limit)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      Mem_Req   <= 1'b0;
      Mem_We    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      IF_Ack    <= 1'b0;
      DM_Ack    <= 1'b0;
      IF_RData  <= '0;
      DM_RData  <= '0;
    end else begin
      IF_Ack <= 1'b0;
      DM_Ack <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_win) begin
            owner     <= OWN_DM;
            Mem_Addr  <= DM_Addr;
            Mem_We    <= DM_We;
            Mem_WData <= DM_WData;
            Mem_Req   <= 1'b1;
            state     <= ISSUE;
          end else if (if_win) begin
            owner    <= OWN_IF;
            Mem_Addr <= IF_Addr;
            Mem_We   <= 1'b0;
            Mem_Req  <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (Mem_Ready) begin
            Mem_Req <= 1'b0;
            Mem_We  <= 1'b0;
            if (owner == OWN_IF) begin
              IF_RData <= Mem_RData;
              IF_Ack   <= 1'b1;
            end else begin
              // Stores complete without disturbing the last load value.
              if (!Mem_We) DM_RData <= Mem_RData;
              DM_Ack <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Stall_IF = IF_Req && !IF_Ack;
  assign Stall_DM = DM_Req && !DM_Ack;

`ifdef ARB_STATS_EN
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Conflict_Cnt <= '0;
    end else if ((state == IDLE) && IF_Req && DM_Req) begin
      Conflict_Cnt <= Conflict_Cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of
// arbitration, latency, data return and memory contents.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          stall_if;
  logic          stall_dm;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
`ifdef ARB_STATS_EN
  logic [31:0]   conflict_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
    .Clk      (clk),
    .Reset    (rst_n),
    .IF_Req   (if_req),
    .IF_Addr  (if_addr),
    .IF_Ack   (if_ack),
    .IF_RData (if_rdata),
    .DM_Req   (dm_req),
    .DM_We    (dm_we),
    .DM_Addr  (dm_addr),
    .DM_WData (dm_wdata),
    .DM_Ack   (dm_ack),
    .DM_RData (dm_rdata),
    .Stall_IF (stall_if),
    .Stall_DM (stall_dm),
    .Mem_Req  (mem_req),
    .Mem_We   (mem_we),
    .Mem_Addr (mem_addr),
    .Mem_WData(mem_wdata),
    .Mem_RData(mem_rdata),
    .Mem_Ready(mem_ready)
`ifdef ARB_STATS_EN
    ,
    .Conflict_Cnt(conflict_cnt)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: phase 0 = arbiter free, 1 = access in flight, 2 = ack just given
  int          phase = 0;
  bit          x_dm = 1'b0;
  bit          x_we = 1'b0;
  logic [31:0] x_addr = '0;
  logic [31:0] x_wdata = '0;
  logic [31:0] x_rdata = '0;
  int          starve = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;
  logic [31:0] conflicts = '0;
  logic [31:0] mem_model [256];
  int          mem_wait = 0;
  int          fix_delay = -1;
  bit          mem_hold = 1'b0;
  int          if_rate = 0;
  int          dm_rate = 0;
  bit          if_keep = 1'b0;
  bit          dm_keep = 1'b0;
  bit          scramble = 1'b1;
  int          if_wait = 0;
  int          dm_wait = 0;
  bit          grant_log[$];

  function automatic logic [31:0] rnd_addr();
    logic [7:0] w;
    w = 8'($urandom);
    return {22'd0, w, 2'b00};
  endfunction

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = rnd_addr();
  endtask

  task automatic new_dm();
    dm_req   = 1'b1;
    dm_we    = 1'($urandom_range(0, 1));
    dm_addr  = rnd_addr();
    dm_wdata = $urandom;
  endtask

  task automatic step();
    bit exp_if_ack;
    bit exp_dm_ack;
    bit exp_req;
    @(negedge clk);
    exp_if_ack = 1'b0;
    exp_dm_ack = 1'b0;
    exp_req    = 1'b0;
    if (phase == 0) begin
      if (if_req && dm_req) conflicts = conflicts + 32'd1;
      if (if_req || dm_req) begin
        x_dm    = dm_req && !(if_req && starve >= LIM);
        x_addr  = x_dm ? dm_addr : if_addr;
        x_we    = x_dm && dm_we;
        x_wdata = dm_wdata;
        if (x_dm) begin
          if (if_req) starve = (starve < LIM) ? starve + 1 : LIM;
        end else begin
          starve = 0;
        end
        grant_log.push_back(x_dm);
        mem_wait = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 4));
        phase    = 1;
        exp_req  = 1'b1;
      end
    end else if (phase == 1) begin
      if (mem_ready) begin
        if (x_dm) begin
          exp_dm_ack = 1'b1;
          if (x_we) mem_model[x_addr[9:2]] = x_wdata;
          else exp_dm_rdata = x_rdata;
        end else begin
          exp_if_ack   = 1'b1;
          exp_if_rdata = x_rdata;
        end
        phase = 2;
      end else begin
        exp_req = 1'b1;
      end
    end else begin
      phase = 0;
    end

    chk("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      chk("mem_addr", mem_addr, x_addr);
      chk("mem_we", 32'(mem_we), 32'(x_we));
      if (x_we) chk("mem_wdata", mem_wdata, x_wdata);
    end
    chk("if_ack", 32'(if_ack), 32'(exp_if_ack));
    chk("dm_ack", 32'(dm_ack), 32'(exp_dm_ack));
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("dm_rdata", dm_rdata, exp_dm_rdata);
    chk("stall_if", 32'(stall_if), 32'(if_req && !exp_if_ack));
    chk("stall_dm", 32'(stall_dm), 32'(dm_req && !exp_dm_ack));
`ifdef ARB_STATS_EN
    chk("conflict_cnt", conflict_cnt, conflicts);
`endif

    if (exp_if_ack) begin
      if_wait = 0;
      if (if_keep) new_if();
      else if_req = 1'b0;
    end else if (!if_req) begin
      if (int'($urandom_range(0, 99)) < if_rate) new_if();
    end else if (phase == 1 && !x_dm && scramble) begin
      if_addr = rnd_addr();
    end
    if (exp_dm_ack) begin
      dm_wait = 0;
      if (dm_keep) new_dm();
      else dm_req = 1'b0;
    end else if (!dm_req) begin
      if (int'($urandom_range(0, 99)) < dm_rate) new_dm();
    end else if (phase == 1 && x_dm && scramble) begin
      dm_addr  = rnd_addr();
      dm_wdata = $urandom;
      dm_we    = 1'($urandom_range(0, 1));
    end
    if (if_req) begin
      if_wait++;
      if (if_wait == 200) chk("if_timeout", 32'(if_wait), 32'd0);
    end
    if (dm_req) begin
      dm_wait++;
      if (dm_wait == 200) chk("dm_timeout", 32'(dm_wait), 32'd0);
    end

    // Ready is only meaningful while an access is in flight; elsewhere it is noise.
    if (phase == 1) begin
      if (mem_wait == 0 && !mem_hold) begin
        x_rdata   = mem_model[x_addr[9:2]];
        mem_ready = 1'b1;
        mem_rdata = x_rdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        if (mem_wait > 0) mem_wait--;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  endtask

  task automatic drain();
    int n;
    if_rate = 0;
    dm_rate = 0;
    if_keep = 1'b0;
    dm_keep = 1'b0;
    n = 0;
    while ((if_req || dm_req || phase != 0) && n < 100) begin
      step();
      n++;
    end
    chk("drain_done", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int exp_seq[6];
    logic [31:0] prev_dm;
    exp_seq = '{1, 1, 1, 1, 0, 1};
    for (int i = 0; i < 256; i++) mem_model[i] = $urandom;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_dm_ack", 32'(dm_ack), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // Lone fetch, memory ready in the first issue cycle.
    drain();
    fix_delay = 0;
    mem_model[16] = 32'h8C08_0004;
    if_req  = 1'b1;
    if_addr = 32'h40;
    n = 0;
    do begin step(); n++; end while (!if_ack && n < 20);
    chk("if_lone_latency", 32'(n), 32'd2);
    chk("if_lone_rdata", if_rdata, 32'h8C08_0004);

    // Simultaneous requests: DM first, then IF.
    drain();
    fix_delay = -1;
    grant_log.delete();
    if_req  = 1'b1;
    if_addr = rnd_addr();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h100;
    n = 0;
    while ((grant_log.size() < 2 || if_req || dm_req) && n < 60) begin step(); n++; end
    chk("both_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      chk("both_first_dm", 32'(grant_log[0]), 32'd1);
      chk("both_second_if", 32'(grant_log[1]), 32'd0);
    end

    // Continuous DM with IF waiting: IF forced through after LIM DM grants.
    drain();
    grant_log.delete();
    dm_keep = 1'b1;
    if_req  = 1'b1;
    if_addr = rnd_addr();
    new_dm();
    n = 0;
    while (grant_log.size() < 6 && n < 200) begin step(); n++; end
    dm_keep = 1'b0;
    chk("starve_grant_count", 32'(grant_log.size() >= 6), 32'd1);
    if (grant_log.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("starve_seq%0d", i), 32'(grant_log[i]), 32'(exp_seq[i]));
    drain();

    // Slow DM store, then read it back.
    prev_dm   = exp_dm_rdata;
    fix_delay = 3;
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 32'h200;
    dm_wdata  = 32'hDEAD_BEEF;
    n = 0;
    do begin step(); n++; end while (!dm_ack && n < 20);
    chk("wr_latency", 32'(n), 32'd5);
    chk("wr_rdata_hold", dm_rdata, prev_dm);
    drain();
    fix_delay = -1;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h200;
    n = 0;
    do begin step(); n++; end while (!dm_ack && n < 20);
    chk("rd_back", dm_rdata, 32'hDEAD_BEEF);

    // Random traffic.
    for (int blk = 0; blk < 15; blk++) begin
      if_rate  = int'($urandom_range(10, 90));
      dm_rate  = int'($urandom_range(10, 90));
      if_keep  = 1'($urandom_range(0, 1));
      dm_keep  = 1'($urandom_range(0, 1));
      repeat (100) step();
    end
    drain();

    // Reset in the middle of an access.
    mem_hold = 1'b1;
    dm_req   = 1'b1;
    dm_we    = 1'b0;
    dm_addr  = rnd_addr();
    n = 0;
    do begin step(); n++; end while (!mem_req && n < 10);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_dm_ack", 32'(dm_ack), 32'd0);
    chk("rst_mid_if_rdata", if_rdata, 32'd0);
    chk("rst_mid_dm_rdata", dm_rdata, 32'd0);
    phase        = 0;
    starve       = 0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    conflicts    = '0;
    dm_req       = 1'b0;
    if_req       = 1'b0;
    dm_wait      = 0;
    if_wait      = 0;
    mem_hold     = 1'b0;
    mem_ready    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = rnd_addr();
    n = 0;
    do begin step(); n++; end while (!dm_ack && n < 20);
    chk("post_rst_access", 32'(dm_ack), 32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
